pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. Combines hazard requests into per-stage write-enable, bubble and flush controls:
- load-use from the hazard detection unit
- taken branch/jump resolved in EX
- multi-cycle mul/div occupying EX
- data-memory wait in MEM

It sits beside the hazard detection unit and drives the PC and pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB). It holds an FSM for the multi-cycle stall sources and a stall-length watchdog.

Parameters:
CNT_W, 8, width of stall-cycle counter
STALL_LIMIT, 200, consecutive stall cycles that set stall_timeout (1..2^CNT_W-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
load_use  in  1  load-use hazard (EX load rd matches ID rs1/rs2)
branch_taken  in  1  branch/jump in EX resolved taken; PC redirect this cycle
md_start  in  1  mul/div instruction present in EX
md_done  in  1  mul/div result valid; level, held by the unit until EX_MEMWrite=1
dmem_busy  in  1  data memory not ready; MEM stage must hold
PCWrite  out  1  PC update enable
IF_IDWrite  out  1  IF_ID register enable
IF_IDFlush  out  1  IF_ID loads NOP
ID_EXWrite  out  1  ID_EX register enable
ID_EXBubble  out  1  ID_EX loads NOP (when ID_EXWrite=1)
EX_MEMWrite  out  1  EX_MEM register enable
EX_MEMBubble  out  1  EX_MEM loads NOP
MEM_WBBubble  out  1  MEM_WB loads NOP
stall_timeout  out  1  sticky watchdog flag
ctrl_state  out  2  FSM state: 0 RUN, 1 MD_BUSY, 2 MEM_WAIT

Behaviour:
- FSM state, counter and stall_timeout are registered. All stage controls are combinational from the current state and inputs, with zero-cycle latency.
- Reset:
  - While rst=1: state=RUN, cnt=0, stall_timeout=0.
  - While rst=1 the outputs are forced: all *Write=0; IF_IDFlush, ID_EXBubble, EX_MEMBubble and MEM_WBBubble =1.
- Default advance: all *Write=1, all flush/bubble=0.
- RUN, evaluated in priority order (first match wins):
  1. dmem_busy=1:
     - PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite =0; MEM_WBBubble=1.
     - Next state MEM_WAIT.
  2. md_start=1 and md_done=0:
     - PCWrite, IF_IDWrite, ID_EXWrite =0; EX_MEMBubble=1.
     - Next state MD_BUSY.
     - branch_taken in the same cycle is a protocol violation and is ignored.
  3. md_start=1 and md_done=1: default advance (single-cycle completion), stay RUN.
  4. branch_taken=1: PCWrite=1, IF_IDFlush=1, ID_EXBubble=1. Overrides load_use, because the dependent instruction is squashed.
  5. load_use=1: PCWrite=0, IF_IDWrite=0, ID_EXBubble=1.
  6. Otherwise: default advance.
- MD_BUSY:
  - md_done=1 and dmem_busy=0: default advance, next state RUN. md_start, load_use and branch_taken are ignored in this cycle.
  - dmem_busy=1: freeze as in RUN rule 1, but stay MD_BUSY.
  - Otherwise: hold as in RUN rule 2.
- MEM_WAIT:
  - dmem_busy=1: freeze as in RUN rule 1.
  - dmem_busy=0: outputs and next state follow RUN rules 2-6 this cycle.
- Counter cnt (CNT_W bits, saturating):
  - Edge RUN -> MD_BUSY/MEM_WAIT: cnt<=1.
  - Edge that stays in MD_BUSY/MEM_WAIT: cnt<=cnt+1, saturating at 2^CNT_W-1.
  - Direct MEM_WAIT -> MD_BUSY: cnt<=cnt+1.
  - Edge to RUN: cnt<=0.
- Watchdog:
  - stall_timeout<=1 on the edge at which cnt becomes STALL_LIMIT.
  - It is sticky until rst and does not alter stage controls.
- Reset asserted mid-stall returns immediately to RUN with the reset output values; no pending state survives.

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_events[31:0].
  - perf_stall_cycles increments on each clock with rst=0 and PCWrite=0.
  - perf_flush_events increments on each clock with rst=0 and IF_IDFlush=1.
  - Both wrap modulo 2^32 and clear on rst.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
1. rst=1 for 3 cycles -> all *Write=0, all bubble/flush=1, ctrl_state=0. Release with inputs 0 -> all *Write=1, all bubble/flush=0.
2. RUN, load_use=1 for 1 cycle -> PCWrite=0, IF_IDWrite=0, ID_EXWrite=1, ID_EXBubble=1. Next cycle load_use=0 -> default advance, ctrl_state=0.
3. RUN, branch_taken=1 and load_use=1 together -> PCWrite=1, IF_IDWrite=1, IF_IDFlush=1, ID_EXBubble=1.
4. md_start=1, md_done rises 4 cycles later -> ctrl_state=1 for 4 cycles with PCWrite=IF_IDWrite=ID_EXWrite=0 and EX_MEMBubble=1. Done cycle -> all *Write=1, then ctrl_state=0.
5. In MD_BUSY, md_done=1 with dmem_busy=1 for 3 cycles -> EX_MEMWrite=0, MEM_WBBubble=1, ctrl_state stays 1. dmem_busy=0 -> advance, return to RUN.
6. STALL_LIMIT=4, dmem_busy held 6 cycles -> ctrl_state=2, stall_timeout=1 after the 4th stall edge and still 1 after return to RUN. Cleared only by rst. With PERF_CNT_EN, perf_stall_cycles=6.

Source files
------------

// File: rtl/pipeline_stall_controller_if.sv
// ============================================================================
// Module      : pipeline_stall_controller_if
// Description : Hazard-request inputs and per-stage stall/flush controls of the
//               pipeline stall controller. PERF_CNT_EN adds the perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_stall_controller_if;
    logic        load_use;
    logic        branch_taken;
    logic        md_start;
    logic        md_done;
    logic        dmem_busy;
    logic        PCWrite;
    logic        IF_IDWrite;
    logic        IF_IDFlush;
    logic        ID_EXWrite;
    logic        ID_EXBubble;
    logic        EX_MEMWrite;
    logic        EX_MEMBubble;
    logic        MEM_WBBubble;
    logic        stall_timeout;
    logic [1:0]  ctrl_state;
`ifdef PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_events;
`endif

    modport master (
        output load_use, branch_taken, md_start, md_done, dmem_busy,
        input  PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXBubble,
               EX_MEMWrite, EX_MEMBubble, MEM_WBBubble, stall_timeout, ctrl_state
`ifdef PERF_CNT_EN
        , input perf_stall_cycles, perf_flush_events
`endif
    );

    modport slave (
        input  load_use, branch_taken, md_start, md_done, dmem_busy,
        output PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXBubble,
               EX_MEMWrite, EX_MEMBubble, MEM_WBBubble, stall_timeout, ctrl_state
`ifdef PERF_CNT_EN
        , output perf_stall_cycles, perf_flush_events
`endif
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
// ============================================================================
// Module      : pipeline_stall_controller
// Description : Stall/flush sequencer for the 5-stage pipeline with a stall
//               watchdog. Optional macro PERF_CNT_EN adds perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stall_controller #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned STALL_LIMIT = 200
) (
    input  wire                            clk,
    input  wire                            rst,
    pipeline_stall_controller_if.slave     ctrl_if
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ACT_ADV     = 3'd0,
        ACT_FREEZE  = 3'd1,
        ACT_MDHOLD  = 3'd2,
        ACT_FLUSH   = 3'd3,
        ACT_LUSTALL = 3'd4
    } action_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;
    action_t          action;

    logic pc_we, ifid_we, ifid_flush, idex_we, idex_bub, exmem_we, exmem_bub, memwb_bub;

    // RUN priority rules, also reused by MEM_WAIT once memory is ready
    function automatic void run_rules(output action_t act, output state_t nxt);
        if (ctrl_if.dmem_busy) begin
            act = ACT_FREEZE;
            nxt = MEM_WAIT;
        end else if (ctrl_if.md_start && !ctrl_if.md_done) begin
            act = ACT_MDHOLD;
            nxt = MD_BUSY;
        end else if (ctrl_if.md_start) begin
            act = ACT_ADV;
            nxt = RUN;
        end else if (ctrl_if.branch_taken) begin
            act = ACT_FLUSH;
            nxt = RUN;
        end else if (ctrl_if.load_use) begin
            act = ACT_LUSTALL;
            nxt = RUN;
        end else begin
            act = ACT_ADV;
            nxt = RUN;
        end
    endfunction

    always_comb begin
        action  = ACT_ADV;
        state_d = RUN;
        case (state_q)
            RUN: run_rules(action, state_d);
            MD_BUSY: begin
                if (ctrl_if.md_done && !ctrl_if.dmem_busy) begin
                    action  = ACT_ADV;
                    state_d = RUN;
                end else if (ctrl_if.dmem_busy) begin
                    action  = ACT_FREEZE;
                    state_d = MD_BUSY;
                end else begin
                    action  = ACT_MDHOLD;
                    state_d = MD_BUSY;
                end
            end
            MEM_WAIT: begin
                if (ctrl_if.dmem_busy) begin
                    action  = ACT_FREEZE;
                    state_d = MEM_WAIT;
                end else begin
                    run_rules(action, state_d);
                end
            end
            default: begin
                action  = ACT_ADV;
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_we    = 1'b1;
        idex_bub   = 1'b0;
        exmem_we   = 1'b1;
        exmem_bub  = 1'b0;
        memwb_bub  = 1'b0;
        if (rst) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_we    = 1'b0;
            idex_bub   = 1'b1;
            exmem_we   = 1'b0;
            exmem_bub  = 1'b1;
            memwb_bub  = 1'b1;
        end else begin
            case (action)
                ACT_FREEZE: begin
                    pc_we     = 1'b0;
                    ifid_we   = 1'b0;
                    idex_we   = 1'b0;
                    exmem_we  = 1'b0;
                    memwb_bub = 1'b1;
                end
                ACT_MDHOLD: begin
                    pc_we     = 1'b0;
                    ifid_we   = 1'b0;
                    idex_we   = 1'b0;
                    exmem_bub = 1'b1;
                end
                ACT_FLUSH: begin
                    ifid_flush = 1'b1;
                    idex_bub   = 1'b1;
                end
                ACT_LUSTALL: begin
                    pc_we    = 1'b0;
                    ifid_we  = 1'b0;
                    idex_bub = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Stall-length counter: restarts on entering a stall state, saturates at all-ones
    always_comb begin
        cnt_d = '0;
        if (state_d != RUN) begin
            if (state_q == RUN)
                cnt_d = CNT_W'(1);
            else if (cnt_q == {CNT_W{1'b1}})
                cnt_d = cnt_q;
            else
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cnt_d == CNT_W'(STALL_LIMIT))
                timeout_q <= 1'b1;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (!pc_we)
                perf_stall_q <= perf_stall_q + 32'd1;
            if (ifid_flush)
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign ctrl_if.perf_stall_cycles = perf_stall_q;
    assign ctrl_if.perf_flush_events = perf_flush_q;
`endif

    assign ctrl_if.PCWrite       = pc_we;
    assign ctrl_if.IF_IDWrite    = ifid_we;
    assign ctrl_if.IF_IDFlush    = ifid_flush;
    assign ctrl_if.ID_EXWrite    = idex_we;
    assign ctrl_if.ID_EXBubble   = idex_bub;
    assign ctrl_if.EX_MEMWrite   = exmem_we;
    assign ctrl_if.EX_MEMBubble  = exmem_bub;
    assign ctrl_if.MEM_WBBubble  = memwb_bub;
    assign ctrl_if.stall_timeout = timeout_q;
    assign ctrl_if.ctrl_state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
// ============================================================================
// Module      : tb_pipeline_stall_controller
// Description : Directed self-checking bench for pipeline_stall_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_stall_controller;

    // {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXBubble, EX_MEMWrite, EX_MEMBubble, MEM_WBBubble}
    localparam logic [7:0] C_ADV     = 8'b1101_0100;
    localparam logic [7:0] C_RST     = 8'b0010_1011;
    localparam logic [7:0] C_FREEZE  = 8'b0000_0001;
    localparam logic [7:0] C_MDHOLD  = 8'b0000_0110;
    localparam logic [7:0] C_FLUSH   = 8'b1111_1100;
    localparam logic [7:0] C_LUSTALL = 8'b0001_1100;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    pipeline_stall_controller_if u_if ();

    pipeline_stall_controller #(
        .CNT_W       (8),
        .STALL_LIMIT (4)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (u_if)
    );

    logic [7:0] ctl;
    assign ctl = {u_if.PCWrite, u_if.IF_IDWrite, u_if.IF_IDFlush, u_if.ID_EXWrite,
                  u_if.ID_EXBubble, u_if.EX_MEMWrite, u_if.EX_MEMBubble, u_if.MEM_WBBubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic lu, input logic br, input logic ms, input logic md, input logic db);
        u_if.load_use     = lu;
        u_if.branch_taken = br;
        u_if.md_start     = ms;
        u_if.md_done      = md;
        u_if.dmem_busy    = db;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        drive(0, 0, 0, 0, 0);

        // reset hold and release
        repeat (3) tick();
        check("rst_ctl", ctl, C_RST);
        check("rst_state", u_if.ctrl_state, 0);
        check("rst_timeout", u_if.stall_timeout, 0);
        rst = 1'b0;
        #1;
        check("rel_ctl", ctl, C_ADV);

        // load-use stall then advance
        drive(1, 0, 0, 0, 0);
        check("lu_ctl", ctl, C_LUSTALL);
        tick();
        drive(0, 0, 0, 0, 0);
        check("lu_after_ctl", ctl, C_ADV);
        check("lu_after_state", u_if.ctrl_state, 0);

        // branch overrides load-use
        drive(1, 1, 0, 0, 0);
        check("br_lu_ctl", ctl, C_FLUSH);
        tick();

        // multi-cycle mul/div: entry cycle, two hold cycles, done cycle
        drive(0, 0, 1, 0, 0);
        check("md_entry_ctl", ctl, C_MDHOLD);
        check("md_entry_state", u_if.ctrl_state, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            check("md_hold_ctl", ctl, C_MDHOLD);
            check("md_hold_state", u_if.ctrl_state, 1);
            tick();
        end
        drive(0, 0, 1, 1, 0);
        check("md_done_ctl", ctl, C_ADV);
        check("md_done_state", u_if.ctrl_state, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        check("md_ret_state", u_if.ctrl_state, 0);
        check("md_no_timeout", u_if.stall_timeout, 0);

        // MD_BUSY with memory wait; cnt reaches the limit of 4 on the third freeze edge
        drive(0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            check("md_mem_ctl", ctl, C_FREEZE);
            check("md_mem_state", u_if.ctrl_state, 1);
            check("md_mem_timeout", u_if.stall_timeout, 0);
            tick();
        end
        check("md_mem_timeout_set", u_if.stall_timeout, 1);
        drive(0, 0, 1, 1, 0);
        check("md_mem_rel_ctl", ctl, C_ADV);
        tick();
        drive(0, 0, 0, 0, 0);
        check("md_mem_ret_state", u_if.ctrl_state, 0);
        check("timeout_sticky_md", u_if.stall_timeout, 1);
`ifdef PERF_CNT_EN
        check("perf_flush", u_if.perf_flush_events, 1);
`endif

        // reset clears the sticky flag, then a 6-cycle memory wait
        rst = 1'b1;
        #1;
        check("rst2_ctl", ctl, C_RST);
        check("rst2_timeout", u_if.stall_timeout, 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 1);
        check("mw_entry_ctl", ctl, C_FREEZE);
        check("mw_entry_state", u_if.ctrl_state, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("mw_state", u_if.ctrl_state, 2);
            check("mw_ctl", ctl, C_FREEZE);
            check("mw_timeout", u_if.stall_timeout, (i >= 3) ? 32'd1 : 32'd0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        check("mw_rel_ctl", ctl, C_ADV);
        check("mw_rel_state", u_if.ctrl_state, 2);
`ifdef PERF_CNT_EN
        check("perf_stall", u_if.perf_stall_cycles, 6);
`endif
        tick();
        check("mw_ret_state", u_if.ctrl_state, 0);
        check("timeout_sticky_mw", u_if.stall_timeout, 1);

        // MEM_WAIT ready with load-use follows RUN rules
        drive(0, 0, 0, 0, 1);
        tick();
        drive(1, 0, 0, 0, 0);
        check("mw_lu_ctl", ctl, C_LUSTALL);
        tick();
        check("mw_lu_state", u_if.ctrl_state, 0);

        // MEM_WAIT directly into MD_BUSY, then reset mid-stall
        drive(0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 1, 0, 0);
        check("mw_md_ctl", ctl, C_MDHOLD);
        tick();
        check("mw_md_state", u_if.ctrl_state, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_ctl", ctl, C_RST);
        check("rst_mid_state", u_if.ctrl_state, 0);
`ifdef PERF_CNT_EN
        check("rst_mid_perf", u_if.perf_stall_cycles, 0);
`endif
        tick();
        drive(0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ctl", ctl, C_ADV);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
